// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transmitter and its FIFO.
//   PAR_NONE/PAR_ODD/PAR_EVEN : values of the PARITY parameter
//   tx_state_e                : transmitter FSM states
//   bps_cnt()                 : clock cycles per bit, integer division
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } tx_state_e;

  function automatic int bps_cnt(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO.
//   clk, rst      : clock, synchronous active-high reset (flushes contents)
//   push, din     : write din when not full
//   pop, dout     : dout shows the oldest entry; pop discards it when not empty
//   full, empty   : occupancy flags
//   level         : current occupancy 0..DEPTH
// Push and pop in the same cycle are both honoured and leave level unchanged.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with an input FIFO and back-to-back framing.
//   sys_clk, sys_rst : clock, synchronous active-high reset
//   tx_data/valid/ready : word input handshake, transfer on valid && ready
//   uart_txd         : registered serial line, idle high, LSB first
//   busy             : frame in progress or FIFO non-empty
//   done             : one-cycle pulse on the last cycle of the final stop bit
//   fifo_level       : FIFO occupancy
// Frame: start(0), DATA_BITS data, optional parity, STOP_BITS stop(1); each
// bit held BPS_CNT cycles. uart_txd is registered from the FSM state, so the
// line trails the FSM by one cycle; done and busy follow the FSM directly.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int SYS_CLK_FRE = 100_000_000,
  parameter int BPS         = 115200,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          uart_txd,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int BPS_CNT = bps_cnt(SYS_CLK_FRE, BPS);
  localparam int CW      = $clog2(2*BPS_CNT);
  localparam int BW      = $clog2(DATA_BITS+1);

  localparam logic [CW-1:0] BIT_LAST  = CW'(BPS_CNT-1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS*BPS_CNT-1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS-1);

  generate
    if (BPS_CNT < 2) begin : g_err_bps
      $error("uart_tx_param: BPS_CNT must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_err_db
      $error("uart_tx_param: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_err_par
      $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_err_sb
      $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH-1)) != 0) begin : g_err_fd
      $error("uart_tx_param: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  tx_state_e             state, state_nxt;
  logic [CW-1:0]         clk_cnt;
  logic [BW-1:0]         bit_idx;
  logic [DATA_BITS-1:0]  shift;
  logic                  par_bit;
  logic [DATA_BITS-1:0]  fifo_dout;
  logic                  fifo_full, fifo_empty;
  logic                  push, pop, bit_wrap;
  logic                  bit_end, stop_end;

  // Ready is forced low while reset is asserted so nothing is accepted
  // into a FIFO that is being flushed.
  assign tx_ready = ~sys_rst & ~fifo_full;
  assign push     = tx_valid & tx_ready;
  assign bit_end  = (clk_cnt == BIT_LAST);
  assign stop_end = (clk_cnt == STOP_LAST);
  assign busy     = (state != S_IDLE) | ~fifo_empty;

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (sys_clk),
    .rst   (sys_rst),
    .push  (push),
    .din   (tx_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    done      = 1'b0;
    bit_wrap  = bit_end;
    case (state)
      S_IDLE: begin
        bit_wrap = 1'b0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START:  if (bit_end) state_nxt = S_DATA;
      S_DATA: begin
        if (bit_end && bit_idx == DATA_LAST)
          state_nxt = (PARITY != PAR_NONE) ? S_PARITY : S_STOP;
      end
      S_PARITY: if (bit_end) state_nxt = S_STOP;
      S_STOP: begin
        // The whole stop period is one count of STOP_BITS*BPS_CNT cycles.
        bit_wrap = stop_end;
        if (stop_end) begin
          done = 1'b1;
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = S_START;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      clk_cnt  <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      uart_txd <= 1'b1;
    end else begin
      if (state == S_IDLE || bit_wrap) clk_cnt <= '0;
      else                             clk_cnt <= clk_cnt + 1'b1;

      if (pop) begin
        shift   <= fifo_dout;
        bit_idx <= '0;
        par_bit <= (PARITY == PAR_ODD) ? ~(^fifo_dout) : ^fifo_dout;
      end else if (state == S_DATA && bit_end) begin
        shift   <= shift >> 1;
        bit_idx <= bit_idx + 1'b1;
      end

      case (state)
        S_START:  uart_txd <= 1'b0;
        S_DATA:   uart_txd <= shift[0];
        S_PARITY: uart_txd <= par_bit;
        default:  uart_txd <= 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: four frame configurations side by side
// (8N1, 8E1, 8O1, 7N2), each with a timeline model of when every accepted
// word occupies the FIFO, the line, and when its done pulse falls.
module tb_uart_tx_param;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int BPS_N  = 10;
  localparam int DEPTH  = 4;
  localparam int MAXW   = 64;

  function automatic int cfg_db(input int g);
    return (g == 3) ? 7 : 8;
  endfunction
  function automatic int cfg_par(input int g);
    return (g == 1) ? 2 : (g == 2) ? 1 : 0;
  endfunction
  function automatic int cfg_sb(input int g);
    return (g == 3) ? 2 : 1;
  endfunction
  // First directed word per configuration.
  function automatic int cfg_w0(input int g);
    return (g == 0) ? 'h55 : (g == 3) ? 'h17F : 'h07;
  endfunction

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input int inst, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s cfg%0d cycle %0d: got %0h expected %0h", tag, inst, cyc, got, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int DB = cfg_db(g);
    localparam int PAR = cfg_par(g);
    localparam int SB = cfg_sb(g);
    localparam int FL = (1 + DB + ((PAR != 0) ? 1 : 0) + SB) * BPS_N;

    logic       rst = 1'b1;
    logic       vld = 1'b0;
    logic [8:0] data9 = '0;
    logic       rdy, txd, bsy, dn;
    logic [2:0] lvl;
    bit         chk_on = 1'b0;
    bit         fin = 1'b0;

    uart_tx_param #(
      .SYS_CLK_FRE (CLK_HZ),
      .BPS         (BAUD),
      .DATA_BITS   (DB),
      .PARITY      (PAR),
      .STOP_BITS   (SB),
      .FIFO_DEPTH  (DEPTH)
    ) dut (
      .sys_clk    (clk),
      .sys_rst    (rst),
      .tx_data    (data9[DB-1:0]),
      .tx_valid   (vld),
      .tx_ready   (rdy),
      .uart_txd   (txd),
      .busy       (bsy),
      .done       (dn),
      .fifo_level (lvl)
    );

    // Per word: accept edge, line interval [start,end), FIFO interval
    // [acc,pop), busy interval [acc,bend), done cycle. Cycle t is the
    // interval following rising edge t.
    int nw = 0;
    int last_end = 0;
    int w_data[MAXW];
    int w_acc[MAXW];
    int w_start[MAXW];
    int w_end[MAXW];
    int w_pop[MAXW];
    int w_bend[MAXW];
    int w_done[MAXW];

    function automatic int fbit(input int d, input int idx);
      int ones;
      if (idx == 0) return 0;
      if (idx <= DB) return (d >> (idx-1)) & 1;
      if (PAR != 0 && idx == DB + 1) begin
        ones = 0;
        for (int k = 0; k < DB; k++) ones += (d >> k) & 1;
        return (PAR == 2) ? (ones % 2) : (1 - ones % 2);
      end
      return 1;
    endfunction

    function automatic int m_level(input int t);
      int n = 0;
      for (int i = 0; i < nw; i++) if (w_acc[i] <= t && t < w_pop[i]) n++;
      return n;
    endfunction
    function automatic int m_txd(input int t);
      for (int i = 0; i < nw; i++)
        if (w_start[i] <= t && t < w_end[i]) return fbit(w_data[i], (t - w_start[i]) / BPS_N);
      return 1;
    endfunction
    function automatic int m_busy(input int t);
      for (int i = 0; i < nw; i++) if (w_acc[i] <= t && t < w_bend[i]) return 1;
      return 0;
    endfunction
    function automatic int m_done(input int t);
      for (int i = 0; i < nw; i++) if (w_done[i] == t) return 1;
      return 0;
    endfunction

    // Model update at each rising edge e.
    initial forever begin
      int e, st;
      @(posedge clk);
      e = cyc + 1;
      if (rst) begin
        for (int i = 0; i < nw; i++) begin
          if (w_end[i]  > e) w_end[i]  = e;
          if (w_pop[i]  > e) w_pop[i]  = e;
          if (w_bend[i] > e) w_bend[i] = e;
          if (w_done[i] >= e) w_done[i] = -1;
        end
        last_end = e;
      end else if (vld && m_level(e-1) != DEPTH && nw < MAXW) begin
        st = (e + 2 > last_end) ? e + 2 : last_end;
        w_data[nw]  = int'(data9);
        w_acc[nw]   = e;
        w_start[nw] = st;
        w_end[nw]   = st + FL;
        w_pop[nw]   = st - 1;
        w_bend[nw]  = st + FL - 1;
        w_done[nw]  = st + FL - 2;
        last_end    = st + FL;
        nw++;
      end
    end

    initial forever begin
      int t;
      @(posedge clk);
      #1;
      t = cyc;
      if (chk_on) begin
        chk("txd",   g, int'(txd), m_txd(t));
        chk("done",  g, int'(dn),  m_done(t));
        chk("busy",  g, int'(bsy), m_busy(t));
        chk("level", g, int'(lvl), m_level(t));
        chk("ready", g, int'(rdy), (rst || m_level(t) == DEPTH) ? 0 : 1);
      end
    end

    // Leaves vld high; the caller drops it when the burst is over.
    task automatic push_one(input int w);
      int n0, k;
      data9 = 9'(w);
      vld = 1'b1;
      n0 = nw;
      k = 0;
      while (nw == n0 && k < 3000) begin
        @(negedge clk);
        k++;
      end
      chk("accept", g, nw - n0, 1);
    endtask

    task automatic wait_idle();
      int k = 0;
      while ((m_busy(cyc) != 0 || cyc < last_end) && k < 5000) begin
        @(negedge clk);
        k++;
      end
      @(negedge clk);
      chk("idle_bsy", g, int'(bsy), 0);
    endtask

    initial begin
      int i, k;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk_on = 1'b1;

      // Single directed frame.
      push_one(cfg_w0(g));
      vld = 1'b0;
      wait_idle();

      // Six words with valid held high: FIFO fills, frames abut.
      for (int n = 0; n < 6; n++) push_one(int'($urandom_range(0, 511)));
      vld = 1'b0;
      wait_idle();

      // New word offered during the done cycle of a lone frame.
      push_one(int'($urandom_range(0, 511)));
      vld = 1'b0;
      i = nw - 1;
      k = 0;
      while (cyc != w_done[i] && k < 3000) begin
        @(negedge clk);
        k++;
      end
      push_one(int'($urandom_range(0, 511)));
      vld = 1'b0;
      wait_idle();

      // Reset in the middle of the second of three queued frames.
      for (int n = 0; n < 3; n++) push_one(int'($urandom_range(0, 511)));
      vld = 1'b0;
      i = nw - 2;
      k = 0;
      while (cyc != w_start[i] + 3*BPS_N && k < 3000) begin
        @(negedge clk);
        k++;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (3 * FL) @(negedge clk);

      // Random words with random gaps.
      for (int n = 0; n < 10; n++) begin
        repeat ($urandom_range(0, 150)) @(negedge clk);
        push_one(int'($urandom_range(0, 511)));
        vld = 1'b0;
      end
      wait_idle();
      fin = 1'b1;
    end
  end

  initial begin
    int k = 0;
    while (!(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin) && k < 60000) begin
      @(posedge clk);
      k++;
    end
    chk("finished", 0, int'(g_cfg[0].fin && g_cfg[1].fin && g_cfg[2].fin && g_cfg[3].fin), 1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
